reg_ctx_sequencer: RTL and testbench

Context save/restore engine for the RISC-V integer register file. It acts as the initiator on the register-file port, so the register file is its responder. On `START_SAVE` it reads x1..x31 through the register file's read port and writes each value to data memory at consecutive words from a context base address. On `START_RESTORE` it reads those words back and writes them into x1..x31 through the register file's write port. The pipeline is stalled via `BUSY` for the whole transfer; this block is the hardware half of a context switch.

---
 rtl/reg_ctx_sequencer_pkg.sv | 15 +
 rtl/reg_ctx_sequencer.sv | 81 ++++++++
 tb/tb_reg_ctx_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_ctx_sequencer_pkg.sv
// reg_ctx_sequencer_pkg: shared state encoding and context layout constants.
package reg_ctx_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SAVE       = 3'd1,
        RESTORE_RD = 3'd2,
        RESTORE_WR = 3'd3,
        FINISH     = 3'd4
    } ctx_state_t;

    localparam int CTX_WORD_BYTES = 4;
    localparam int CTX_FIRST_REG  = 1;

endpackage

// File: rtl/reg_ctx_sequencer.sv
// reg_ctx_sequencer: saves x1..x31 to memory or restores them from memory,
// holding BUSY high so the pipeline stalls for the whole context switch.
module reg_ctx_sequencer
    import reg_ctx_sequencer_pkg::*;
#(
    parameter int REG_COUNT = 32,
    parameter int RADDR_W   = 5,
    parameter int DATA_W    = 32
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START_SAVE,
    input  logic               START_RESTORE,
    input  logic [31:0]        CTX_BASE,
    output logic               BUSY,
    output logic               DONE,
    output logic [RADDR_W-1:0] OUT1ADDRESS,
    input  logic [DATA_W-1:0]  OUT1,
    output logic [RADDR_W-1:0] INADDRESS,
    output logic [DATA_W-1:0]  IN,
    output logic               WRITE,
    output logic [31:0]        MEM_ADDRESS,
    output logic [DATA_W-1:0]  MEM_WRITEDATA,
    output logic               MEM_WRITE,
    output logic               MEM_READ,
    input  logic [DATA_W-1:0]  MEM_READDATA,
    input  logic               MEM_BUSYWAIT
);

    ctx_state_t         state;
    logic [RADDR_W-1:0] idx;
    logic [31:0]        base;
    logic [31:0]        addr;
    logic               last;

    assign last = idx == RADDR_W'(REG_COUNT - 1);
    assign addr = base + 32'(idx) * 32'(CTX_WORD_BYTES);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            idx   <= '0;
            base  <= '0;
            IN    <= '0;
        end else begin
            case (state)
                IDLE: if (START_SAVE || START_RESTORE) begin
                    state <= START_SAVE ? SAVE : RESTORE_RD;
                    idx   <= RADDR_W'(CTX_FIRST_REG);
                    base  <= CTX_BASE;
                end
                SAVE: if (!MEM_BUSYWAIT) begin
                    if (last) state <= FINISH;
                    else idx <= idx + 1'b1;
                end
                RESTORE_RD: if (!MEM_BUSYWAIT) begin
                    IN    <= MEM_READDATA;
                    state <= RESTORE_WR;
                end
                RESTORE_WR: begin
                    state <= last ? FINISH : RESTORE_RD;
                    if (!last) idx <= idx + 1'b1;
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign BUSY          = state != IDLE;
    assign DONE          = state == FINISH;
    assign MEM_WRITE     = state == SAVE;
    assign MEM_READ      = state == RESTORE_RD;
    assign WRITE         = state == RESTORE_WR;
    assign OUT1ADDRESS   = MEM_WRITE ? idx : '0;
    assign INADDRESS     = WRITE ? idx : '0;
    assign MEM_ADDRESS   = (MEM_WRITE || MEM_READ) ? addr : '0;
    assign MEM_WRITEDATA = MEM_WRITE ? OUT1 : '0;

endmodule

// File: tb/tb_reg_ctx_sequencer.sv
// tb_reg_ctx_sequencer: scoreboard bench with register-file and memory models;
// expected transfers are queued at issue and popped by a negedge monitor.
module tb_reg_ctx_sequencer;

    logic        CLK = 0, RESET = 1, START_SAVE = 0, START_RESTORE = 0;
    logic [31:0] CTX_BASE = 0;
    logic        BUSY, DONE, WRITE, MEM_WRITE, MEM_READ, MEM_BUSYWAIT;
    logic [4:0]  OUT1ADDRESS, INADDRESS;
    logic [31:0] OUT1, IN, MEM_ADDRESS, MEM_WRITEDATA;
    logic [31:0] MEM_READDATA = 0;

    reg_ctx_sequencer dut (
        .CLK(CLK), .RESET(RESET), .START_SAVE(START_SAVE), .START_RESTORE(START_RESTORE),
        .CTX_BASE(CTX_BASE), .BUSY(BUSY), .DONE(DONE), .OUT1ADDRESS(OUT1ADDRESS), .OUT1(OUT1),
        .INADDRESS(INADDRESS), .IN(IN), .WRITE(WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_WRITE(MEM_WRITE), .MEM_READ(MEM_READ),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic [31:0] a; logic [31:0] d; } xact_t;

    logic [31:0] rf [32];
    logic [31:0] mem [logic [31:0]];
    xact_t       exp_wq[$], exp_regq[$];
    logic [31:0] exp_rq[$];
    int          exp_done[$];
    int          errors = 0, checks = 0, cyc = 0, start_cyc = 0;
    int          nwrites = 0, nreads = 0, nregw = 0, stalls = 0, scnt = 0;

    assign OUT1 = rf[OUT1ADDRESS];
    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && scnt != 0;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!(MEM_READ || MEM_WRITE) || scnt == 0) scnt <= stalls;
        else scnt <= scnt - 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    always @(negedge CLK) begin
        if (MEM_READ) MEM_READDATA = memrd(MEM_ADDRESS);
        if (!RESET) begin
            chk("strobe_excl", {31'b0, MEM_READ & MEM_WRITE}, 32'h0);
            if (MEM_WRITE) begin
                if (exp_wq.size() == 0) flag("unexpected_mem_write");
                else begin
                    chk("mem_wr_addr", MEM_ADDRESS, exp_wq[0].a);
                    chk("mem_wr_data", MEM_WRITEDATA, exp_wq[0].d);
                    if (!MEM_BUSYWAIT) begin
                        void'(exp_wq.pop_front());
                        mem[MEM_ADDRESS] = MEM_WRITEDATA;
                        nwrites++;
                    end
                end
            end
            if (MEM_READ) begin
                nreads++;
                if (exp_rq.size() == 0) flag("unexpected_mem_read");
                else begin
                    chk("mem_rd_addr", MEM_ADDRESS, exp_rq[0]);
                    if (!MEM_BUSYWAIT) void'(exp_rq.pop_front());
                end
            end
            if (WRITE) begin
                nregw++;
                if (exp_regq.size() == 0) flag("unexpected_reg_write");
                else begin
                    chk("reg_wr_addr", {27'b0, INADDRESS}, exp_regq[0].a);
                    chk("reg_wr_data", IN, exp_regq[0].d);
                    void'(exp_regq.pop_front());
                    if (INADDRESS != 0) rf[INADDRESS] = IN;
                end
            end
            if (DONE) begin
                if (exp_done.size() == 0) flag("unexpected_done");
                else chk("done_cycle", cyc - start_cyc + 1, exp_done.pop_front());
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, {31'b0, BUSY}, 0);
        chk({tag, "_done"}, {31'b0, DONE}, 0);
        chk({tag, "_write"}, {31'b0, WRITE}, 0);
        chk({tag, "_mem_write"}, {31'b0, MEM_WRITE}, 0);
        chk({tag, "_mem_read"}, {31'b0, MEM_READ}, 0);
        chk({tag, "_out1addr"}, {27'b0, OUT1ADDRESS}, 0);
        chk({tag, "_inaddr"}, {27'b0, INADDRESS}, 0);
        chk({tag, "_in"}, IN, 0);
        chk({tag, "_mem_addr"}, MEM_ADDRESS, 0);
        chk({tag, "_mem_wdata"}, MEM_WRITEDATA, 0);
    endtask

    task automatic queue_op(input bit save, input logic [31:0] base, input int s);
        stalls = s;
        for (int i = 1; i < 32; i++) begin
            if (save) exp_wq.push_back({base + 32'(i) * 4, rf[i]});
            else begin
                exp_rq.push_back(base + 32'(i) * 4);
                exp_regq.push_back({32'(i), memrd(base + 32'(i) * 4)});
            end
        end
        exp_done.push_back(save ? 31 * (1 + s) + 1 : 31 * (2 + s) + 1);
    endtask

    task automatic pulse_start(input bit sv, input bit rs, input logic [31:0] base);
        @(negedge CLK);
        START_SAVE = sv;
        START_RESTORE = rs;
        CTX_BASE = base;
        @(negedge CLK);
        START_SAVE = 0;
        START_RESTORE = 0;
        start_cyc = cyc;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge CLK);
            seen = DONE;
        end
        if (!seen) flag("done_timeout");
        @(negedge CLK);
        chk("busy_after_done", {31'b0, BUSY}, 0);
        chk("wq_drained", exp_wq.size(), 0);
        chk("rq_drained", exp_rq.size(), 0);
        chk("regq_drained", exp_regq.size(), 0);
    endtask

    task automatic run_op(input bit save, input logic [31:0] base, input int s);
        queue_op(save, base, s);
        pulse_start(save, !save, base);
        wait_done();
    endtask

    initial begin
        logic [31:0] b;
        bit sv;
        int wc;
        for (int i = 0; i < 32; i++) rf[i] = 0;
        repeat (3) @(negedge CLK);
        check_zero("reset");
        RESET = 0;
        @(negedge CLK);
        check_zero("idle");

        for (int i = 1; i < 32; i++) rf[i] = 32'(i * 3);
        foreach (exp_done[k]) exp_done[k] = exp_done[k];
        for (int s = 0; s <= 2; s += 2) begin
            mem.delete();
            run_op(1, 32'h100, s);
            chk("x0_not_saved", {31'b0, mem.exists(32'h100)}, 0);
            for (int i = 1; i < 32; i++) chk("saved_word", memrd(32'h100 + 32'(i) * 4), 32'(i * 3));
        end

        mem.delete();
        for (int i = 1; i < 32; i++) begin
            mem[32'h200 + 32'(i) * 4] = 32'hA000 + 32'(i);
            rf[i] = 0;
        end
        nregw = 0;
        run_op(0, 32'h200, 0);
        chk("restore_write_count", nregw, 31);
        chk("x0_zero", rf[0], 0);
        for (int i = 1; i < 32; i++) chk("restored_reg", rf[i], 32'hA000 + 32'(i));

        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        mem.delete();
        nreads = 0;
        nregw = 0;
        b = $urandom & 32'hFFFF_FFFC;
        queue_op(1, b, 0);
        pulse_start(1, 1, b);
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK);
            START_RESTORE = (cyc - start_cyc + 1) == 10;
            if (DONE) break;
        end
        START_RESTORE = 0;
        repeat (5) @(negedge CLK);
        chk("both_no_reads", nreads, 0);
        chk("both_no_regw", nregw, 0);
        chk("both_idle", {31'b0, BUSY}, 0);
        chk("both_wq_drained", exp_wq.size(), 0);
        chk("both_done_drained", exp_done.size(), 0);

        queue_op(1, 32'h300, 0);
        pulse_start(1, 0, 32'h300);
        while ((cyc - start_cyc + 1) < 15) @(negedge CLK);
        RESET = 1;
        #1;
        check_zero("midreset");
        exp_wq.delete();
        exp_done.delete();
        wc = nwrites;
        repeat (2) @(negedge CLK);
        RESET = 0;
        repeat (40) @(negedge CLK);
        chk("no_write_after_reset", nwrites, wc);
        chk("idle_after_reset", {31'b0, BUSY}, 0);

        for (int t = 0; t < 6; t++) begin
            sv = 1'($urandom_range(0, 1));
            b = (t == 0) ? 32'hFFFF_FFF0 : $urandom;
            mem.delete();
            for (int i = 1; i < 32; i++) begin
                if (sv) rf[i] = $urandom;
                else mem[b + 32'(i) * 4] = $urandom;
            end
            run_op(sv, b, $urandom_range(0, 3));
            for (int i = 1; i < 32; i++)
                chk(sv ? "rand_saved" : "rand_restored", sv ? memrd(b + 32'(i) * 4) : rf[i],
                    sv ? rf[i] : memrd(b + 32'(i) * 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
